// File: rtl/counter_cmd_arbiter.sv
// Round-robin arbiter that shares one up/down step counter between two
// requesters, A and B. The winner's 2-bit command is driven onto W1/W0 for
// exactly Len cycles. The owner then gets a one-cycle Done pulse.
//
// Ports:
//   Clock        system clock, rising edge
//   Reset        asynchronous reset, active low
//   ReqA/ReqB    request, held high until the matching Done
//   CmdA/CmdB    command {w1,w0}: 00 hold, 01 +1, 10 +2, 11 -1
//   LenA/LenB    burst length in cycles (0 = no command, Done only)
//   GntA/GntB    current owner of the counter
//   DoneA/DoneB  one-cycle pulse at the end of the owner's burst
//   W1/W0        command bits to the counter FSM
//   Busy         high in any state other than IDLE
module counter_cmd_arbiter #(
    parameter int unsigned LEN_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             ReqA,
    input  logic [1:0]       CmdA,
    input  logic [LEN_W-1:0] LenA,
    input  logic             ReqB,
    input  logic [1:0]       CmdB,
    input  logic [LEN_W-1:0] LenB,
    output logic             GntA,
    output logic             GntB,
    output logic             DoneA,
    output logic             DoneB,
    output logic             W1,
    output logic             W0,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic             ptr_b;      // 1: B wins a tie, 0: A wins a tie
    logic             owner_b;    // 1: B owns the current burst
    logic [LEN_W-1:0] rem;        // cycles still to issue after the current one

    logic             pick_b_c;
    logic [1:0]       sel_cmd_c;
    logic [LEN_W-1:0] sel_len_c;
    logic             owner_req_c;

    // Arbitration: B wins when it is the only requester or the pointer favours it
    always_comb begin
        pick_b_c    = ReqB && (!ReqA || ptr_b);
        sel_cmd_c   = pick_b_c ? CmdB : CmdA;
        sel_len_c   = pick_b_c ? LenB : LenA;
        owner_req_c = owner_b ? ReqB : ReqA;
    end

    // Single FSM. The command and length are captured on the granting edge,
    // because W1/W0 and rem hold them for the rest of the burst.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            ptr_b   <= 1'b0;
            owner_b <= 1'b0;
            rem     <= '0;
            GntA    <= 1'b0;
            GntB    <= 1'b0;
            DoneA   <= 1'b0;
            DoneB   <= 1'b0;
            W1      <= 1'b0;
            W0      <= 1'b0;
            Busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqA || ReqB) begin
                        owner_b <= pick_b_c;
                        GntA    <= !pick_b_c;
                        GntB    <= pick_b_c;
                        Busy    <= 1'b1;
                        if (sel_len_c != '0) begin
                            state    <= ISSUE;
                            {W1, W0} <= sel_cmd_c;
                            rem      <= sel_len_c - LEN_W'(1);
                        end else begin
                            // Zero-length burst: acknowledge without issuing
                            state <= DONE;
                            DoneA <= !pick_b_c;
                            DoneB <= pick_b_c;
                        end
                    end
                end

                ISSUE: begin
                    if (!owner_req_c) begin
                        // Owner withdrew: abort without Done, still hand priority over
                        state    <= IDLE;
                        {W1, W0} <= 2'b00;
                        GntA     <= 1'b0;
                        GntB     <= 1'b0;
                        Busy     <= 1'b0;
                        rem      <= '0;
                        ptr_b    <= !owner_b;
                    end else if (rem != '0) begin
                        rem <= rem - LEN_W'(1);
                    end else begin
                        state    <= DONE;
                        {W1, W0} <= 2'b00;
                        DoneA    <= !owner_b;
                        DoneB    <= owner_b;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    GntA  <= 1'b0;
                    GntB  <= 1'b0;
                    DoneA <= 1'b0;
                    DoneB <= 1'b0;
                    Busy  <= 1'b0;
                    ptr_b <= !owner_b;
                end

                default: begin
                    state    <= IDLE;
                    {W1, W0} <= 2'b00;
                    GntA     <= 1'b0;
                    GntB     <= 1'b0;
                    DoneA    <= 1'b0;
                    DoneB    <= 1'b0;
                    Busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Self-checking bench for counter_cmd_arbiter. Directed scenarios use
// constant expectations. The randomized run uses a burst-schedule model.
// On a grant, the model queues the whole future output trace: Len issue
// cycles, one Done cycle and one idle cycle. An abort flushes that trace.
module tb_counter_cmd_arbiter;

    localparam int unsigned LEN_W = 4;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             ReqA, ReqB;
    logic [1:0]       CmdA, CmdB;
    logic [LEN_W-1:0] LenA, LenB;
    logic             GntA, GntB, DoneA, DoneB, W1, W0, Busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the queued output trace, the current expectation, and the tie pointer
    logic [6:0] exp_q[$];
    logic [6:0] cur_exp;
    logic       mdl_ptr_b;

    counter_cmd_arbiter #(.LEN_W(LEN_W)) dut (
        .Clock(Clock), .Reset(Reset),
        .ReqA(ReqA), .CmdA(CmdA), .LenA(LenA),
        .ReqB(ReqB), .CmdB(CmdB), .LenB(LenB),
        .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
        .W1(W1), .W0(W0), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    // Output vector layout: {GntA, GntB, DoneA, DoneB, W1, W0, Busy}
    function automatic logic [6:0] ent(input logic ga, input logic gb, input logic da,
                                       input logic db, input logic [1:0] w, input logic bz);
        return {ga, gb, da, db, w, bz};
    endfunction

    function automatic logic [6:0] obs();
        return {GntA, GntB, DoneA, DoneB, W1, W0, Busy};
    endfunction

    function automatic int delta(input logic [1:0] w);
        case (w)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return -1;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        exp_q.delete();
        cur_exp   = '0;
        mdl_ptr_b = 1'b0;
    endtask

    // Advance the model by one rising edge, using the inputs seen before the edge
    task automatic model_step();
        logic             pick_b;
        logic [1:0]       c;
        int               l;
        logic             in_issue;
        logic             own_req;
        in_issue = (cur_exp[6] || cur_exp[5]) && !cur_exp[4] && !cur_exp[3];
        own_req  = cur_exp[5] ? ReqB : ReqA;
        if (in_issue && !own_req) begin
            exp_q.delete();
            cur_exp = '0;
            return;
        end
        if (exp_q.size() == 0 && (ReqA || ReqB)) begin
            pick_b    = (ReqA && ReqB) ? mdl_ptr_b : ReqB;
            mdl_ptr_b = !pick_b;
            c = pick_b ? CmdB : CmdA;
            l = int'(pick_b ? LenB : LenA);
            for (int i = 0; i < l; i++)
                exp_q.push_back(ent(!pick_b, pick_b, 1'b0, 1'b0, c, 1'b1));
            exp_q.push_back(ent(!pick_b, pick_b, !pick_b, pick_b, 2'b00, 1'b1));
            exp_q.push_back('0);
        end
        cur_exp = (exp_q.size() != 0) ? exp_q.pop_front() : 7'd0;
    endtask

    task automatic tick();
        @(posedge Clock);
        model_step();
        @(negedge Clock);
    endtask

    task automatic apply_reset();
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        ReqA = 1'b0; ReqB = 1'b0;
        CmdA = 2'b00; CmdB = 2'b00; LenA = '0; LenB = '0;
        model_reset();
        repeat (2) begin
            @(negedge Clock);
            n_checks++;
            if (obs() !== 7'd0) begin
                n_fail++;
                $display("FAIL reset_hold: got %b want %b", obs(), 7'd0);
            end
        end
        Reset = 1'b1;
        repeat (10) begin
            tick();
            n_checks++;
            if (obs() !== 7'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset: got %b want %b", obs(), 7'd0);
            end
        end
    endtask

    task automatic test_single_burst();
        logic [6:0] want [5];
        int cnt = 0;
        want = '{ent(1,0,0,0,2'b01,1), ent(1,0,0,0,2'b01,1), ent(1,0,0,0,2'b01,1),
                 ent(1,0,1,0,2'b00,1), 7'd0};
        ReqA = 1'b1; CmdA = 2'b01; LenA = 4'd3;
        for (int i = 0; i < 5; i++) begin
            tick();
            cnt += delta({W1, W0});
            n_checks++;
            if (obs() !== want[i]) begin
                n_fail++;
                $display("FAIL single_burst[%0d]: got %b want %b", i, obs(), want[i]);
            end
            if (i == 0) begin
                CmdA = 2'b11; LenA = 4'd9;   // must be ignored after the grant
            end
            if (i == 3) ReqA = 1'b0;
        end
        n_checks++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL single_burst_count: got %0d want 3", cnt);
        end
    endtask

    task automatic test_contention();
        logic [6:0] want [8];
        int cnt = 0;
        want = '{ent(1,0,0,0,2'b10,1), ent(1,0,0,0,2'b10,1), ent(1,0,1,0,2'b00,1), 7'd0,
                 ent(0,1,0,0,2'b11,1), ent(0,1,0,1,2'b00,1), 7'd0, ent(1,0,0,0,2'b10,1)};
        @(negedge Clock);
        Reset = 1'b0;
        model_reset();
        ReqA = 1'b1; CmdA = 2'b10; LenA = 4'd2;
        ReqB = 1'b1; CmdB = 2'b11; LenB = 4'd1;
        @(negedge Clock);
        Reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 7) cnt += delta({W1, W0});
            n_checks++;
            if (obs() !== want[i]) begin
                n_fail++;
                $display("FAIL contention[%0d]: got %b want %b", i, obs(), want[i]);
            end
            n_checks++;
            if (GntA && GntB) begin
                n_fail++;
                $display("FAIL contention_overlap[%0d]: got GntA=%b GntB=%b want not both", i, GntA, GntB);
            end
        end
        n_checks++;
        if (cnt != 3) begin
            n_fail++;
            $display("FAIL contention_count: got %0d want 3", cnt);
        end
        ReqA = 1'b0; ReqB = 1'b0;
        apply_reset();
    endtask

    task automatic test_zero_len();
        logic [6:0] want [3];
        int busy_cycles = 0;
        want = '{ent(0,1,0,1,2'b00,1), 7'd0, 7'd0};
        ReqB = 1'b1; CmdB = 2'b01; LenB = 4'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (Busy) busy_cycles++;
            n_checks++;
            if (obs() !== want[i]) begin
                n_fail++;
                $display("FAIL zero_len[%0d]: got %b want %b", i, obs(), want[i]);
            end
            ReqB = 1'b0;
        end
        n_checks++;
        if (busy_cycles != 1) begin
            n_fail++;
            $display("FAIL zero_len_busy: got %0d cycles want 1", busy_cycles);
        end
    endtask

    task automatic test_abort();
        logic [6:0] want [8];
        want = '{ent(1,0,0,0,2'b01,1), ent(1,0,0,0,2'b01,1), ent(1,0,0,0,2'b01,1), 7'd0,
                 ent(0,1,0,0,2'b10,1), ent(0,1,0,0,2'b10,1), ent(0,1,0,1,2'b00,1), 7'd0};
        apply_reset();
        ReqA = 1'b1; CmdA = 2'b01; LenA = 4'd8;
        ReqB = 1'b1; CmdB = 2'b10; LenB = 4'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_checks++;
            if (obs() !== want[i]) begin
                n_fail++;
                $display("FAIL abort[%0d]: got %b want %b", i, obs(), want[i]);
            end
            if (i == 2) ReqA = 1'b0;
            if (i == 6) ReqB = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        // First A burst completes so the pointer moves to B before the reset
        ReqA = 1'b1; CmdA = 2'b01; LenA = 4'd1;
        tick();
        tick();
        CmdA = 2'b11; LenA = 4'd5;
        tick();
        tick();
        tick();
        n_checks++;
        if (obs() !== ent(1,0,0,0,2'b11,1)) begin
            n_fail++;
            $display("FAIL async_pre: got %b want %b", obs(), ent(1,0,0,0,2'b11,1));
        end
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 7'd0) begin
            n_fail++;
            $display("FAIL async_clear: got %b want %b", obs(), 7'd0);
        end
        model_reset();
        ReqB = 1'b1; CmdB = 2'b10; LenB = 4'd1;
        CmdA = 2'b01; LenA = 4'd1;
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        n_checks++;
        if (obs() !== ent(1,0,0,0,2'b01,1)) begin
            n_fail++;
            $display("FAIL async_ptr_a: got %b want %b", obs(), ent(1,0,0,0,2'b01,1));
        end
        ReqA = 1'b0; ReqB = 1'b0;
        apply_reset();
    endtask

    task automatic test_random();
        ReqA = 1'b0; ReqB = 1'b0;
        apply_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick();
            n_checks++;
            if (obs() !== cur_exp) begin
                n_fail++;
                $display("FAIL random[%0d]: got %b want %b", cyc, obs(), cur_exp);
            end
            n_checks++;
            if ((GntA && GntB) || (DoneA && !GntA) || (DoneB && !GntB)) begin
                n_fail++;
                $display("FAIL random_invariant[%0d]: got %b want exclusive grants and Done within grant", cyc, obs());
            end
            // New stimulus for the next edge
            if (!ReqA) ReqA = ($urandom_range(3) == 0);
            else if ($urandom_range(29) == 0) ReqA = 1'b0;
            else if (DoneA && $urandom_range(1) == 0) ReqA = 1'b0;
            if (!ReqB) ReqB = ($urandom_range(3) == 0);
            else if ($urandom_range(29) == 0) ReqB = 1'b0;
            else if (DoneB && $urandom_range(1) == 0) ReqB = 1'b0;
            if ($urandom_range(3) == 0) begin
                CmdA = 2'($urandom);
                LenA = ($urandom_range(7) == 0) ? '1 : LEN_W'($urandom_range(6));
            end
            if ($urandom_range(3) == 0) begin
                CmdB = 2'($urandom);
                LenB = ($urandom_range(7) == 0) ? '1 : LEN_W'($urandom_range(6));
            end
        end
        ReqA = 1'b0; ReqB = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_contention();
        test_zero_len();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
